err_pipe_sched: RTL

ERR_PIPE_SCHED -- requirements
Module: err_pipe_sched

---
 rtl/err_pipe_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/err_pipe_sched.sv
// err_pipe_sched
//   Two-channel round-robin issue scheduler for a shared fixed-latency
//   error pipeline (int2FP -> multFP -> addFP). Each channel may have one
//   sample in flight at a time; a LAT-deep tag line tracks which channel
//   owns the result that emerges from the pipeline.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[1:0]     per-channel sample-ready level
//   data0/data1  13-bit signed samples per channel
//   vref0/vref1  64-bit double current reference per channel
//   grant[1:0]   one-hot, one-cycle acknowledge of the consumed request
//   pipe_valid   issue strobe to the shared pipeline (= |grant)
//   pipe_data    issued sample (holds last issued value between issues)
//   pipe_vref    issued reference (holds last issued value between issues)
//   pipe_result  pipeline output, valid LAT cycles after issue
//   e_out        registered error result
//   e_ch         channel that owns e_out
//   e_ready      one-cycle pulse when e_out/e_ch update
//   busy[1:0]    per-channel in-flight flag
module err_pipe_sched #(
  parameter int unsigned LAT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [12:0] data0,
  input  logic [12:0] data1,
  input  logic [63:0] vref0,
  input  logic [63:0] vref1,
  output logic [1:0]  grant,
  output logic        pipe_valid,
  output logic [12:0] pipe_data,
  output logic [63:0] pipe_vref,
  input  logic [63:0] pipe_result,
  output logic [63:0] e_out,
  output logic        e_ch,
  output logic        e_ready,
  output logic [1:0]  busy
);

  typedef enum logic {
    IDLE     = 1'b0,
    INFLIGHT = 1'b1
  } ch_state_t;

  ch_state_t        state_q [2];
  ch_state_t        state_d [2];
  logic             ptr_q;
  logic             ptr_d;
  logic [LAT-1:0]   tag_v_q;
  logic [LAT-1:0]   tag_ch_q;
  logic [12:0]      data_hold_q;
  logic [63:0]      vref_hold_q;
  logic [1:0]       elig;
  logic             gnt_ch;
  logic             tag_out_v;
  logic             tag_out_ch;

  assign tag_out_v  = tag_v_q[LAT-1];
  assign tag_out_ch = tag_ch_q[LAT-1];

  // Arbitration and issue path.
  always_comb begin
    elig[0]   = req[0] && (state_q[0] == IDLE);
    elig[1]   = req[1] && (state_q[1] == IDLE);
    grant     = '0;
    gnt_ch    = 1'b0;
    // grant is combinational, so it is gated by rst to stay low while
    // the register state is being forced.
    if (!rst) begin
      unique case (elig)
        2'b01: begin
          grant  = 2'b01;
          gnt_ch = 1'b0;
        end
        2'b10: begin
          grant  = 2'b10;
          gnt_ch = 1'b1;
        end
        2'b11: begin
          grant  = ptr_q ? 2'b10 : 2'b01;
          gnt_ch = ptr_q;
        end
        default: begin
          grant  = '0;
          gnt_ch = 1'b0;
        end
      endcase
    end
    pipe_valid = |grant;
    pipe_data  = data_hold_q;
    pipe_vref  = vref_hold_q;
    if (pipe_valid) begin
      pipe_data = gnt_ch ? data1 : data0;
      pipe_vref = gnt_ch ? vref1 : vref0;
    end
    ptr_d = pipe_valid ? ~gnt_ch : ptr_q;
  end

  // Per-channel next state. A returning tag and a new grant never target
  // the same channel in one cycle: a channel is only granted while IDLE
  // and only returns from INFLIGHT.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      busy[i]    = (state_q[i] == INFLIGHT);
      if (tag_out_v && (tag_out_ch == i[0])) begin
        state_d[i] = IDLE;
      end
      if (grant[i]) begin
        state_d[i] = INFLIGHT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= '{default: IDLE};
      ptr_q       <= 1'b0;
      tag_v_q     <= '0;
      tag_ch_q    <= '0;
      data_hold_q <= '0;
      vref_hold_q <= '0;
      e_out       <= '0;
      e_ch        <= 1'b0;
      e_ready     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      // Tag enters at stage 0 on the issue edge and reaches stage LAT-1
      // exactly in the cycle the pipeline presents the matching result.
      tag_v_q  <= {tag_v_q[LAT-2:0], pipe_valid};
      tag_ch_q <= {tag_ch_q[LAT-2:0], gnt_ch};
      if (pipe_valid) begin
        data_hold_q <= pipe_data;
        vref_hold_q <= pipe_vref;
      end
      e_ready <= tag_out_v;
      if (tag_out_v) begin
        e_out <= pipe_result;
        e_ch  <= tag_out_ch;
      end
    end
  end

endmodule
